pc_unit: RTL and testbench

- Parametrised program-counter unit that replaces the plain enable/reset PC register.
- Holds the current PC and computes next-PC for sequential, branch, jump, jump-register, return and exception-return flows.
- Captures EPC on exceptions and keeps a small circular return-address stack (RAS) for call/return.
- Sits at the head of the fetch stage. It is driven by the control unit (mode select, stall, exception) and by decode/execute (offset, target, register value).

---
 rtl/pc_pkg.sv | 22 ++
 rtl/pc_ras.sv | 56 +++++
 rtl/pc_unit.sv | 92 +++++++++
 tb/tb_pc_unit.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// pc_pkg: shared definitions for the program-counter unit.
//   pc_sel_e  - next-PC mode encodings driven on pc_unit.sel
//   PC_INC    - sequential PC increment in bytes
//   ras_cnt_w - width of a RAS occupancy counter able to hold 0..depth
package pc_pkg;

  typedef enum logic [2:0] {
    PC_SEQ  = 3'd0,
    PC_BR   = 3'd1,
    PC_JMP  = 3'd2,
    PC_JR   = 3'd3,
    PC_RET  = 3'd4,
    PC_ERET = 3'd5
  } pc_sel_e;

  localparam int unsigned PC_INC = 4;

  function automatic int unsigned ras_cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack.
//   clk, reset - clock, asynchronous active-high reset
//   push, din  - write din above the current top (overwrites oldest when full)
//   pop        - discard the top entry (ignored when empty)
//   top        - current top entry, 0 when empty
//   count      - number of valid entries (saturates at RAS_DEPTH)
//   empty      - count == 0
// push together with pop replaces the top entry in place.
module pc_ras
  import pc_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned RAS_DEPTH = 4,
  localparam int unsigned CW       = ras_cnt_w(RAS_DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic [CW-1:0]    count,
  output logic             empty
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);

  logic [WIDTH-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    ptr_up;
  logic             do_pop;

  assign ptr_up = ptr + PW'(1);
  assign do_pop = pop && (count != '0);
  assign empty  = (count == '0);
  assign top    = empty ? '0 : mem[ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < RAS_DEPTH; i++) mem[i] <= '0;
      ptr   <= '0;
      count <= '0;
    end else if (do_pop && push) begin
      // pop followed by push lands on the same slot
      mem[ptr] <= din;
    end else if (push) begin
      ptr         <= ptr_up;
      mem[ptr_up] <= din;
      if (count != CW'(RAS_DEPTH)) count <= count + CW'(1);
    end else if (do_pop) begin
      ptr   <= ptr - PW'(1);
      count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: program counter with next-PC selection, EPC capture and RAS.
//   clk, reset  - clock, asynchronous active-high reset
//   en          - update enable (0 holds pc, epc and RAS)
//   sel         - next-PC mode (pc_sel_e encodings, 6/7 behave as SEQ)
//   br_offset   - sign-extended word offset for BR
//   target      - absolute jump target for JMP
//   rs_val      - register value for JR
//   push        - call: push pc_plus onto the RAS
//   exc         - exception: pc <= EXC_VECTOR, epc <= pc (overrides en)
//   pc, pc_plus - current PC, pc + 4
//   epc         - captured PC of the faulting instruction
//   ras_top, ras_count, ras_empty - RAS status
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned       WIDTH        = 32,
  parameter logic [WIDTH-1:0]  RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0]  EXC_VECTOR   = WIDTH'('h180),
  parameter int unsigned       RAS_DEPTH    = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           en,
  input  logic [2:0]                     sel,
  input  logic [WIDTH-1:0]               br_offset,
  input  logic [WIDTH-1:0]               target,
  input  logic [WIDTH-1:0]               rs_val,
  input  logic                           push,
  input  logic                           exc,
  output logic [WIDTH-1:0]               pc,
  output logic [WIDTH-1:0]               pc_plus,
  output logic [WIDTH-1:0]               epc,
  output logic [WIDTH-1:0]               ras_top,
  output logic [ras_cnt_w(RAS_DEPTH)-1:0] ras_count,
  output logic                           ras_empty
);

  pc_sel_e          sel_e;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] jmp_pc;
  logic             ras_push;
  logic             ras_pop;

  assign sel_e   = pc_sel_e'(sel);
  assign pc_plus = pc + WIDTH'(PC_INC);

  // RAS only moves on an enabled, non-exception cycle
  assign ras_push = en && !exc && push;
  assign ras_pop  = en && !exc && (sel_e == PC_RET);

  always_comb begin
    // region bits above 27 come from pc_plus; written this way so WIDTH == 28 works
    jmp_pc       = pc_plus;
    jmp_pc[27:0] = {target[25:0], 2'b00};
    nxt          = pc_plus;
    case (sel_e)
      PC_BR:   nxt = pc_plus + (br_offset << 2);
      PC_JMP:  nxt = jmp_pc;
      PC_JR:   nxt = {rs_val[WIDTH-1:2], 2'b00};
      PC_RET:  nxt = ras_empty ? pc_plus : ras_top;
      PC_ERET: nxt = epc;
      default: nxt = pc_plus;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc  <= RESET_VECTOR;
      epc <= '0;
    end else if (exc) begin
      pc  <= EXC_VECTOR;
      epc <= pc;
    end else if (en) begin
      pc <= nxt;
    end
  end

  pc_ras #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk   (clk),
    .reset (reset),
    .push  (ras_push),
    .pop   (ras_pop),
    .din   (pc_plus),
    .top   (ras_top),
    .count (ras_count),
    .empty (ras_empty)
  );

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [2:0]  sel;
  logic [31:0] br_offset, target, rs_val;
  logic        push, exc;
  logic [31:0] pc, pc_plus, epc, ras_top;
  logic [2:0]  ras_count;
  logic        ras_empty;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pc_unit #(
    .WIDTH        (32),
    .RESET_VECTOR (32'h0),
    .EXC_VECTOR   (32'h0000_0180),
    .RAS_DEPTH    (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .sel       (sel),
    .br_offset (br_offset),
    .target    (target),
    .rs_val    (rs_val),
    .push      (push),
    .exc       (exc),
    .pc        (pc),
    .pc_plus   (pc_plus),
    .epc       (epc),
    .ras_top   (ras_top),
    .ras_count (ras_count),
    .ras_empty (ras_empty)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: PC, EPC and the RAS as a bounded queue (oldest at front)
  logic [31:0] m_pc, m_epc, m_pp, m_nx;
  logic [31:0] ras_q[$];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pc  = 32'h0;
      m_epc = 32'h0;
      ras_q.delete();
    end else begin
      m_pp = m_pc + 32'd4;
      if (exc) begin
        m_epc = m_pc;
        m_pc  = 32'h180;
      end else if (en) begin
        m_nx = m_pp;
        case (sel)
          3'd1: m_nx = m_pp + (br_offset * 32'd4);
          3'd2: m_nx = (m_pp & 32'hF000_0000) | ((target & 32'h03FF_FFFF) * 32'd4);
          3'd3: m_nx = rs_val & 32'hFFFF_FFFC;
          3'd4: if (ras_q.size() > 0) m_nx = ras_q[ras_q.size()-1];
          3'd5: m_nx = m_epc;
          default: m_nx = m_pp;
        endcase
        if (sel == 3'd4 && ras_q.size() > 0) begin
          if (push) ras_q[ras_q.size()-1] = m_pp;
          else void'(ras_q.pop_back());
        end else if (push) begin
          if (ras_q.size() == 4) void'(ras_q.pop_front());
          ras_q.push_back(m_pp);
        end
        m_pc = m_nx;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("pc",        pc,        m_pc);
      check("pc_plus",   pc_plus,   m_pc + 32'd4);
      check("epc",       epc,       m_epc);
      check("ras_top",   ras_top,   (ras_q.size() > 0) ? ras_q[ras_q.size()-1] : 32'h0);
      check("ras_count", {29'd0, ras_count}, ras_q.size());
      check("ras_empty", {31'd0, ras_empty}, {31'd0, ras_q.size() == 0});
    end
  end

  // Drive one cycle of inputs; returns 2 time units after the edge that consumed them
  task automatic step(input logic i_en, input logic [2:0] i_sel, input logic [31:0] i_br,
                      input logic [31:0] i_tgt, input logic [31:0] i_rs,
                      input logic i_push, input logic i_exc);
    en = i_en; sel = i_sel; br_offset = i_br; target = i_tgt; rs_val = i_rs;
    push = i_push; exc = i_exc;
    @(posedge clk);
    #2;
  endtask

  task automatic call_to(input logic [31:0] dest);
    step(1'b1, 3'd2, 32'h0, dest >> 2, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic ret(input logic i_push);
    step(1'b1, 3'd4, 32'h0, 32'h0, 32'h0, i_push, 1'b0);
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; sel = 3'd0; br_offset = '0; target = '0; rs_val = '0;
    push = 1'b0; exc = 1'b0;
    #12;
    check("rst_pc", pc, 32'h0);
    check("rst_epc", epc, 32'h0);
    check("rst_cnt", {29'd0, ras_count}, 32'd0);
    check("rst_top", ras_top, 32'h0);
    reset = 1'b0;

    // sequential
    step(1'b1, 3'd0, '0, '0, '0, 1'b0, 1'b0); check("seq1", pc, 32'h4);
    step(1'b1, 3'd0, '0, '0, '0, 1'b0, 1'b0); check("seq2", pc, 32'h8);
    step(1'b1, 3'd0, '0, '0, '0, 1'b0, 1'b0); check("seq3", pc, 32'hC);
    // unused encodings act as SEQ
    step(1'b1, 3'd6, '0, '0, '0, 1'b0, 1'b0); check("sel6", pc, 32'h10);
    step(1'b1, 3'd7, '0, '0, '0, 1'b0, 1'b0); check("sel7", pc, 32'h14);

    // asynchronous reset between edges
    #1 reset = 1'b1;
    #1 check("async_rst", pc, 32'h0);
    #2 reset = 1'b0;
    @(posedge clk); #2;

    // branch backwards, stall, then JR with misaligned value
    step(1'b1, 3'd3, '0, '0, 32'h100, 1'b0, 1'b0); check("jr100", pc, 32'h100);
    step(1'b1, 3'd1, 32'hFFFF_FFFE, '0, '0, 1'b0, 1'b0); check("br_neg", pc, 32'hFC);
    step(1'b0, 3'd3, '0, '0, 32'h203, 1'b1, 1'b0); check("stall", pc, 32'hFC);
    check("stall_ras", {29'd0, ras_count}, 32'd0);
    step(1'b1, 3'd3, '0, '0, 32'h203, 1'b0, 1'b0); check("jr_mis", pc, 32'h200);

    // exception while stalled, then ERET
    step(1'b1, 3'd3, '0, '0, 32'h40, 1'b0, 1'b0);
    step(1'b0, 3'd0, '0, '0, '0, 1'b0, 1'b1);
    check("exc_pc", pc, 32'h180);
    check("exc_epc", epc, 32'h40);
    step(1'b1, 3'd5, '0, '0, '0, 1'b0, 1'b0); check("eret", pc, 32'h40);

    // five calls into a depth-4 RAS
    step(1'b1, 3'd3, '0, '0, 32'h10, 1'b0, 1'b0);
    call_to(32'h20); call_to(32'h30); call_to(32'h40); call_to(32'h50); call_to(32'h60);
    check("full_cnt", {29'd0, ras_count}, 32'd4);
    check("full_top", ras_top, 32'h54);
    ret(1'b0); check("ret1", pc, 32'h54);
    ret(1'b0); check("ret2", pc, 32'h44);
    ret(1'b0); check("ret3", pc, 32'h34);
    ret(1'b0); check("ret4", pc, 32'h24);
    ret(1'b0); check("ret_empty", pc, 32'h28);
    check("empty_flag", {31'd0, ras_empty}, 32'd1);

    // push together with RET replaces the top
    step(1'b1, 3'd3, '0, '0, 32'h20, 1'b0, 1'b0);
    call_to(32'h80);
    check("call_pc", pc, 32'h80);
    check("call_top", ras_top, 32'h24);
    ret(1'b1);
    check("pushret_pc", pc, 32'h24);
    check("pushret_top", ras_top, 32'h84);
    check("pushret_cnt", {29'd0, ras_count}, 32'd1);

    // exception beats push+RET; RAS untouched
    step(1'b1, 3'd4, '0, '0, '0, 1'b1, 1'b1);
    check("exc2_pc", pc, 32'h180);
    check("exc2_epc", epc, 32'h24);
    check("exc2_top", ras_top, 32'h84);
    check("exc2_cnt", {29'd0, ras_count}, 32'd1);

    step(1'b1, 3'd0, '0, '0, '0, 1'b0, 1'b0);
    @(negedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
